// File: rtl/id_stage.sv
// id_stage: registered RV32I decode stage sitting between fetch and execute.
// Decodes one instruction per cycle into the ID/EX register. Handles the
// valid/ready handshake, redirect flush, load-use stalling and illegal
// opcode flagging.
module id_stage #(
  parameter int XLEN      = 32,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_regWrite,
  output logic            ex_memToReg,
  output logic            ex_memWrite,
  output logic            ex_operandA,
  output logic            ex_operandB,
  output logic            ex_branch,
  output logic            ex_jalEN,
  output logic            ex_jalrEN,
  output logic [5:0]      ex_aluOP,
  output logic            ex_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Everything that must read as zero while the register holds a bubble.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       operand_a;
    logic       operand_b;
    logic       branch;
    logic       jal_en;
    logic       jalr_en;
    logic [5:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // Immediate extraction, each sign-extended from instr[31] to XLEN.
  function automatic logic signed [XLEN-1:0] imm_i(input logic [31:0] ins);
    return XLEN'($signed(ins[31:20]));
  endfunction

  function automatic logic signed [XLEN-1:0] imm_s(input logic [31:0] ins);
    return XLEN'($signed({ins[31:25], ins[11:7]}));
  endfunction

  function automatic logic signed [XLEN-1:0] imm_b(input logic [31:0] ins);
    return XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  endfunction

  function automatic logic signed [XLEN-1:0] imm_u(input logic [31:0] ins);
    return XLEN'($signed({ins[31:12], 12'b0}));
  endfunction

  function automatic logic signed [XLEN-1:0] imm_j(input logic [31:0] ins);
    return XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
  endfunction

  logic [6:0]             opcode_p0;
  logic [2:0]             funct3_p0;
  ctrl_t                  ctrl_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [4:0]             rs1_p0;
  logic [4:0]             rs2_p0;
  logic [4:0]             rd_p0;

  logic                   vld_p1;
  ctrl_t                  ctrl_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic [XLEN-1:0]        pc_p1;
  logic [4:0]             rs1_p1;
  logic [4:0]             rs2_p1;
  logic [4:0]             rd_p1;

  logic                   advance;
  logic                   load_use;

  assign opcode_p0 = if_instr[6:0];
  assign funct3_p0 = if_instr[14:12];

  // Decode the fetched word into controls, immediate and masked register indices.
  always_comb begin
    ctrl_p0 = '0;
    imm_p0  = '0;
    rs1_p0  = if_instr[19:15];
    rs2_p0  = if_instr[24:20];
    rd_p0   = if_instr[11:7];
    case (opcode_p0)
      OP_R: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.alu_op    = {if_instr[30], funct3_p0, 2'b00};
      end
      OP_IMM: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.operand_b = 1'b1;
        ctrl_p0.alu_op    = {(funct3_p0 == 3'b101) & if_instr[30], funct3_p0, 2'b00};
        imm_p0            = imm_i(if_instr);
        rs2_p0            = 5'd0;
      end
      OP_LOAD: begin
        ctrl_p0.reg_write  = 1'b1;
        ctrl_p0.mem_to_reg = 1'b1;
        ctrl_p0.operand_b  = 1'b1;
        ctrl_p0.alu_op     = 6'b000010;
        imm_p0             = imm_i(if_instr);
        rs2_p0             = 5'd0;
      end
      OP_STORE: begin
        ctrl_p0.mem_write = 1'b1;
        ctrl_p0.operand_b = 1'b1;
        ctrl_p0.alu_op    = 6'b000010;
        imm_p0            = imm_s(if_instr);
        rd_p0             = 5'd0;
      end
      OP_BRANCH: begin
        ctrl_p0.branch = 1'b1;
        ctrl_p0.alu_op = {1'b0, funct3_p0, 2'b01};
        imm_p0         = imm_b(if_instr);
        rd_p0          = 5'd0;
      end
      OP_JAL: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.jal_en    = 1'b1;
        ctrl_p0.operand_a = 1'b1;
        ctrl_p0.operand_b = 1'b1;
        ctrl_p0.alu_op    = 6'b000010;
        imm_p0            = imm_j(if_instr);
        rs1_p0            = 5'd0;
        rs2_p0            = 5'd0;
      end
      OP_JALR: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.jalr_en   = 1'b1;
        ctrl_p0.operand_b = 1'b1;
        ctrl_p0.alu_op    = 6'b000010;
        imm_p0            = imm_i(if_instr);
        rs2_p0            = 5'd0;
      end
      OP_LUI: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.operand_b = 1'b1;
        ctrl_p0.alu_op    = 6'b000011;
        imm_p0            = imm_u(if_instr);
        rs1_p0            = 5'd0;
        rs2_p0            = 5'd0;
      end
      OP_AUIPC: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.operand_a = 1'b1;
        ctrl_p0.operand_b = 1'b1;
        ctrl_p0.alu_op    = 6'b000010;
        imm_p0            = imm_u(if_instr);
        rs1_p0            = 5'd0;
        rs2_p0            = 5'd0;
      end
      default: begin
        // Unknown opcode: only the flag is raised, nothing writes or branches.
        ctrl_p0.illegal = 1'b1;
        rs2_p0          = 5'd0;
      end
    endcase
  end

  // A LOAD in ID/EX whose destination feeds the instruction now in ID must
  // wait one cycle, since its data is not available to a forward yet.
  assign advance  = !vld_p1 || ex_ready;
  assign load_use = HAZARD_EN && if_valid && vld_p1 && ctrl_p1.mem_to_reg &&
                    (rd_p1 != 5'd0) && ((rd_p1 == rs1_p0) || (rd_p1 == rs2_p0));
  assign id_ready = flush || (advance && !load_use);

  // ---- ID -> EX register boundary ----
  // Update the ID/EX register: flush beats stall, stall beats hazard bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      imm_p1  <= '0;
      pc_p1   <= '0;
      rs1_p1  <= '0;
      rs2_p1  <= '0;
      rd_p1   <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else if (advance) begin
      if (load_use || !if_valid) begin
        // Bubble: controls cleared, data fields keep their last value.
        vld_p1  <= 1'b0;
        ctrl_p1 <= '0;
      end else begin
        vld_p1  <= 1'b1;
        ctrl_p1 <= ctrl_p0;
        imm_p1  <= imm_p0;
        pc_p1   <= if_pc;
        rs1_p1  <= rs1_p0;
        rs2_p1  <= rs2_p0;
        rd_p1   <= rd_p0;
      end
    end
  end

  assign ex_valid    = vld_p1;
  assign ex_pc       = pc_p1;
  assign ex_imm      = imm_p1;
  assign ex_rs1      = rs1_p1;
  assign ex_rs2      = rs2_p1;
  assign ex_rd       = rd_p1;
  assign ex_regWrite = ctrl_p1.reg_write;
  assign ex_memToReg = ctrl_p1.mem_to_reg;
  assign ex_memWrite = ctrl_p1.mem_write;
  assign ex_operandA = ctrl_p1.operand_a;
  assign ex_operandB = ctrl_p1.operand_b;
  assign ex_branch   = ctrl_p1.branch;
  assign ex_jalEN    = ctrl_p1.jal_en;
  assign ex_jalrEN   = ctrl_p1.jalr_en;
  assign ex_aluOP    = ctrl_p1.alu_op;
  assign ex_illegal  = ctrl_p1.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by random traffic, with
// both a hazard-enabled and a hazard-disabled instance checked every cycle
// against a behavioural model of the decode rules.
module tb_id_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regWrite;
    logic        memToReg;
    logic        memWrite;
    logic        operandA;
    logic        operandB;
    logic        branch;
    logic        jalEN;
    logic        jalrEN;
    logic [5:0]  aluOP;
    logic        illegal;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n, if_valid, flush, ex_ready;
  logic [31:0] if_instr, if_pc;

  logic        id_ready, ex_valid, ex_regWrite, ex_memToReg, ex_memWrite;
  logic        ex_operandA, ex_operandB, ex_branch, ex_jalEN, ex_jalrEN, ex_illegal;
  logic [31:0] ex_pc, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [5:0]  ex_aluOP;

  logic        h0_id_ready, h0_ex_valid, h0_ex_regWrite, h0_ex_memToReg, h0_ex_memWrite;
  logic        h0_ex_operandA, h0_ex_operandB, h0_ex_branch, h0_ex_jalEN, h0_ex_jalrEN;
  logic        h0_ex_illegal;
  logic [31:0] h0_ex_pc, h0_ex_imm;
  logic [4:0]  h0_ex_rs1, h0_ex_rs2, h0_ex_rd;
  logic [5:0]  h0_ex_aluOP;

  out_t dut_o, h0_o;
  out_t st0, st1;
  logic rdy0;
  bit   inited = 1'b0;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .HAZARD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regWrite(ex_regWrite), .ex_memToReg(ex_memToReg), .ex_memWrite(ex_memWrite),
    .ex_operandA(ex_operandA), .ex_operandB(ex_operandB), .ex_branch(ex_branch),
    .ex_jalEN(ex_jalEN), .ex_jalrEN(ex_jalrEN), .ex_aluOP(ex_aluOP), .ex_illegal(ex_illegal)
  );

  id_stage #(.XLEN(32), .HAZARD_EN(1'b0)) dut_h0 (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(h0_id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(h0_ex_valid),
    .ex_pc(h0_ex_pc), .ex_imm(h0_ex_imm), .ex_rs1(h0_ex_rs1), .ex_rs2(h0_ex_rs2),
    .ex_rd(h0_ex_rd), .ex_regWrite(h0_ex_regWrite), .ex_memToReg(h0_ex_memToReg),
    .ex_memWrite(h0_ex_memWrite), .ex_operandA(h0_ex_operandA),
    .ex_operandB(h0_ex_operandB), .ex_branch(h0_ex_branch), .ex_jalEN(h0_ex_jalEN),
    .ex_jalrEN(h0_ex_jalrEN), .ex_aluOP(h0_ex_aluOP), .ex_illegal(h0_ex_illegal)
  );

  assign dut_o = {ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_regWrite, ex_memToReg,
                  ex_memWrite, ex_operandA, ex_operandB, ex_branch, ex_jalEN, ex_jalrEN,
                  ex_aluOP, ex_illegal};
  assign h0_o  = {h0_ex_valid, h0_ex_pc, h0_ex_imm, h0_ex_rs1, h0_ex_rs2, h0_ex_rd,
                  h0_ex_regWrite, h0_ex_memToReg, h0_ex_memWrite, h0_ex_operandA,
                  h0_ex_operandB, h0_ex_branch, h0_ex_jalEN, h0_ex_jalrEN, h0_ex_aluOP,
                  h0_ex_illegal};

  // Reference decode built from the opcode-class rules.
  function automatic out_t decode_ref(input logic [31:0] ins, input logic [31:0] pc);
    out_t        d;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] sgn;
    bit r, ia, ld, st, br, jal, jalr, lui, aui, legal;
    op   = ins[6:0];
    f3   = ins[14:12];
    sgn  = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    r    = (op == 7'h33); ia  = (op == 7'h13); ld   = (op == 7'h03);
    st   = (op == 7'h23); br  = (op == 7'h63); jal  = (op == 7'h6F);
    jalr = (op == 7'h67); lui = (op == 7'h37); aui  = (op == 7'h17);
    legal = r | ia | ld | st | br | jal | jalr | lui | aui;
    d = '0;
    d.valid    = 1'b1;
    d.pc       = pc;
    d.rd       = ins[11:7];
    d.rs1      = ins[19:15];
    d.rs2      = ins[24:20];
    d.regWrite = r | ia | ld | jal | jalr | lui | aui;
    d.memToReg = ld;
    d.memWrite = st;
    d.branch   = br;
    d.jalEN    = jal;
    d.jalrEN   = jalr;
    d.operandA = aui | jal;
    d.operandB = legal & !r & !br;
    d.illegal  = !legal;
    d.aluOP[5]   = (r || (ia && f3 == 3'd5)) ? ins[30] : 1'b0;
    d.aluOP[4:2] = (r | ia | br) ? f3 : 3'd0;
    d.aluOP[1:0] = br ? 2'd1 : (ld | st | jal | jalr | aui) ? 2'd2 : lui ? 2'd3 : 2'd0;
    if (ld | ia | jalr) d.imm = (sgn << 12) | 32'(ins[31:20]);
    if (st) d.imm = (sgn << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
    if (br) d.imm = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) |
                    (32'(ins[11:8]) << 1);
    if (lui | aui) d.imm = ins & 32'hFFFF_F000;
    if (jal) d.imm = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) |
                     (32'(ins[30:21]) << 1);
    if (st | br) d.rd = 5'd0;
    if (!(r | st | br)) d.rs2 = 5'd0;
    if (lui | aui | jal) d.rs1 = 5'd0;
    return d;
  endfunction

  // Bubble keeps the data fields, drops validity and all controls.
  function automatic out_t bubble(input out_t s);
    out_t k;
    k = '0;
    k.pc = s.pc; k.imm = s.imm; k.rs1 = s.rs1; k.rs2 = s.rs2; k.rd = s.rd;
    return k;
  endfunction

  // One-cycle model of the register, given the current inputs.
  function automatic void step(input bit hz, input out_t s, input out_t d,
                               output out_t n, output logic rdy);
    bit adv, lu;
    adv = !s.valid || ex_ready;
    lu  = hz && if_valid && s.valid && s.memToReg && (s.rd != 0) &&
          (s.rd == d.rs1 || s.rd == d.rs2);
    rdy = flush || (adv && !lu);
    if (!rst_n)               n = '0;
    else if (flush)           n = bubble(s);
    else if (!adv)            n = s;
    else if (lu || !if_valid) n = bubble(s);
    else                      n = d;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, checking id_ready before the edge and state after it.
  task automatic tick();
    out_t d, n0, n1;
    logic r0, r1;
    #1;
    d = decode_ref(if_instr, if_pc);
    step(1'b1, st0, d, n0, r0);
    step(1'b0, st1, d, n1, r1);
    if (inited) begin
      chk("id_ready", 128'(id_ready), 128'(r0));
      chk("h0_id_ready", 128'(h0_id_ready), 128'(r1));
    end
    rdy0 = r0;
    @(posedge clk);
    #1;
    st0 = n0;
    st1 = n1;
    inited = 1'b1;
    chk("state", 128'(dut_o), 128'(st0));
    chk("h0_state", 128'(h0_o), 128'(st1));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  op;
    w = $urandom;
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 11))
      0:       op = 7'h33;
      1:       op = 7'h13;
      2:       op = 7'h23;
      3:       op = 7'h63;
      4:       op = 7'h6F;
      5:       op = 7'h67;
      6:       op = 7'h37;
      7:       op = 7'h17;
      8:       op = 7'($urandom);
      default: op = 7'h03;
    endcase
    w[6:0] = op;
    return w;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
    flush = 1'b0; ex_ready = 1'b1; st0 = '0; st1 = '0; rdy0 = 1'b1;

    // Reset held for two cycles, then released with nothing fetched.
    tick();
    tick();
    chk("reset_valid", 128'(ex_valid), 128'(0));
    chk("reset_pc", 128'(ex_pc), 128'(0));
    chk("reset_imm", 128'(ex_imm), 128'(0));
    rst_n = 1'b1;
    tick();
    chk("release_valid", 128'(ex_valid), 128'(0));

    // ALU stream: addi x1,x0,4 then sub x4,x2,x1.
    if_valid = 1'b1; if_instr = 32'h00400093; if_pc = 32'h100;
    tick();
    chk("addi_rd", 128'(ex_rd), 128'(1));
    chk("addi_rs1", 128'(ex_rs1), 128'(0));
    chk("addi_imm", 128'(ex_imm), 128'(4));
    chk("addi_alu", 128'(ex_aluOP), 128'(6'b000000));
    chk("addi_opb", 128'(ex_operandB), 128'(1));
    chk("addi_rw", 128'(ex_regWrite), 128'(1));
    if_instr = 32'h40110233; if_pc = 32'h104;
    tick();
    chk("sub_rd", 128'(ex_rd), 128'(4));
    chk("sub_rs1", 128'(ex_rs1), 128'(2));
    chk("sub_rs2", 128'(ex_rs2), 128'(1));
    chk("sub_alu", 128'(ex_aluOP), 128'(6'b100000));
    chk("sub_opb", 128'(ex_operandB), 128'(0));

    // Load-use: lw x5,0(x1) then add x6,x5,x1.
    if_instr = 32'h0000A283; if_pc = 32'h108;
    tick();
    chk("lw_m2r", 128'(ex_memToReg), 128'(1));
    chk("lw_rd", 128'(ex_rd), 128'(5));
    if_instr = 32'h00128333; if_pc = 32'h10C;
    #1;
    chk("lu_id_ready", 128'(id_ready), 128'(0));
    chk("h0_lu_id_ready", 128'(h0_id_ready), 128'(1));
    tick();
    chk("lu_bubble", 128'(ex_valid), 128'(0));
    chk("h0_no_bubble", 128'(h0_ex_valid), 128'(1));
    chk("h0_add_rs1", 128'(h0_ex_rs1), 128'(5));
    chk("lu_ready_after", 128'(id_ready), 128'(1));
    tick();
    chk("add_valid", 128'(ex_valid), 128'(1));
    chk("add_rs1", 128'(ex_rs1), 128'(5));
    chk("add_rd", 128'(ex_rd), 128'(6));

    // Backpressure: three stalled cycles, then release into addi x7,x1,2.
    if_instr = 32'h00208393; if_pc = 32'h110; ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_id_ready", 128'(id_ready), 128'(0));
      tick();
      chk("bp_valid", 128'(ex_valid), 128'(1));
      chk("bp_rd", 128'(ex_rd), 128'(6));
      chk("bp_pc", 128'(ex_pc), 128'(32'h10C));
    end
    ex_ready = 1'b1;
    tick();
    chk("bp_release_rd", 128'(ex_rd), 128'(7));
    chk("bp_release_imm", 128'(ex_imm), 128'(2));

    // Flush while execute is stalled.
    ex_ready = 1'b0; flush = 1'b1;
    #1;
    chk("flush_id_ready", 128'(id_ready), 128'(1));
    tick();
    chk("flush_valid", 128'(ex_valid), 128'(0));
    chk("flush_rw", 128'(ex_regWrite), 128'(0));
    flush = 1'b0;

    // Reset arriving during a stall drops the held instruction.
    ex_ready = 1'b1; if_instr = 32'h00400093; if_pc = 32'h200;
    tick();
    ex_ready = 1'b0; rst_n = 1'b0;
    tick();
    chk("rst_stall_valid", 128'(ex_valid), 128'(0));
    chk("rst_stall_pc", 128'(ex_pc), 128'(0));
    rst_n = 1'b1; ex_ready = 1'b1;

    // Illegal opcode and store masking.
    if_instr = 32'h0000007F; if_pc = 32'h300;
    tick();
    chk("ill_flag", 128'(ex_illegal), 128'(1));
    chk("ill_valid", 128'(ex_valid), 128'(1));
    chk("ill_rw", 128'(ex_regWrite), 128'(0));
    chk("ill_mw", 128'(ex_memWrite), 128'(0));
    if_instr = 32'h0010A023; if_pc = 32'h304;
    tick();
    chk("sw_rd", 128'(ex_rd), 128'(0));
    chk("sw_mw", 128'(ex_memWrite), 128'(1));
    if_instr = 32'h0010A2A3; if_pc = 32'h308;
    tick();
    chk("sw5_rd", 128'(ex_rd), 128'(0));
    chk("sw5_imm", 128'(ex_imm), 128'(5));
    chk("sw5_rs2", 128'(ex_rs2), 128'(1));

    // Random traffic obeying the fetch hold rule.
    for (int i = 0; i < 600; i++) begin
      if (!(if_valid && !rdy0)) begin
        if_valid = ($urandom_range(0, 3) != 0);
        if_instr = rand_instr();
        if_pc    = $urandom & 32'hFFFF_FFFC;
      end
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      rst_n    = ($urandom_range(0, 63) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Registered RV32I instruction-decode stage: the pipelined successor to the single-cycle `ControlDecoder`. It sits between the fetch stage and the execute stage of the pipelined core. It decodes one instruction per cycle into the same control set as the single-cycle decoder and holds the result in the ID/EX pipeline register. It adds a valid/ready handshake, flush on redirect, load-use hazard stalling and illegal-opcode flagging.

## Interface
- `XLEN`, 32: data/PC/immediate width (32 or 64; immediate sign-extended to XLEN).
- `HAZARD_EN`, 1: 1 = load-use detection active; 0 = never stall for hazards.
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `if_valid` in 1: fetch presents an instruction.
- `if_instr` in 32: instruction word.
- `if_pc` in XLEN: PC of `if_instr`.
- `id_ready` out 1: stage accepts `if_instr` this cycle.
- `flush` in 1: redirect from EX (taken branch/jump); kill in-flight instruction.
- `ex_ready` in 1: execute accepts the ID/EX register contents.
- `ex_valid` out 1: ID/EX register holds a live instruction.
- `ex_pc` out XLEN, `ex_imm` out XLEN: registered PC and sign-extended immediate.
- `ex_rs1`, `ex_rs2`, `ex_rd` out 5 each: register indices.
- `ex_regWrite`, `ex_memToReg`, `ex_memWrite`, `ex_operandA`, `ex_operandB`, `ex_branch`, `ex_jalEN`, `ex_jalrEN` out 1 each: control bits.
- `ex_aluOP` out 6: ALU operation code.
- `ex_illegal` out 1: unsupported opcode decoded.

## Operation
- **Supported opcodes:** R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- **Illegal opcodes:** any other opcode sets `ex_illegal`=1 and forces all write/branch controls to 0.
- **`ex_aluOP` layout:**
  - `[5]` = instr[30] for R-type, and for I-ALU only when funct3=101; otherwise 0.
  - `[4:2]` = funct3 for R, I-ALU and BRANCH; otherwise 000.
  - `[1:0]` = class: 00 ALU reg/imm, 01 branch compare, 10 address add (LOAD/STORE/JAL/JALR/AUIPC), 11 pass-B (LUI).
- **Immediate format:**
  - I: LOAD, I-ALU, JALR.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC.
  - J: JAL.
  - R-type: imm = 0.
- **Operand selects:**
  - `operandA`=1 (PC) for AUIPC and JAL.
  - `operandB`=1 (imm) for every non-R, non-BRANCH opcode.
- **Write controls:**
  - `regWrite`=1 for R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC.
  - `memToReg`=1 for LOAD only; `memWrite`=1 for STORE only.
- **Register-index masking:**
  - `rd` forced to 0 for STORE and BRANCH.
  - `rs2` forced to 0 for non-R, non-STORE, non-BRANCH opcodes.
  - `rs1` forced to 0 for LUI, AUIPC, JAL.
- **`advance`** = !`ex_valid` | `ex_ready`.
- **`load_use`** = HAZARD_EN & `if_valid` & `ex_valid` & `ex_memToReg` & (`ex_rd`≠0) & (`ex_rd`==decoded `rs1` | `ex_rd`==decoded `rs2`), using the masked indices.
- **`id_ready`** = `flush` | (`advance` & !`load_use`).
- **Register update, priority order:**
  1. `flush`: `ex_valid`←0; incoming instruction discarded.
  2. !`advance`: hold all ID/EX fields.
  3. `load_use`: insert bubble, `ex_valid`←0; instruction stays at fetch.
  4. Else: load decoded fields; `ex_valid`←`if_valid`.
- **Bubbles:** while `ex_valid`=0, all control outputs are 0. Data fields are don't-care but held at their last value.

## Timing
- Latency: 1 cycle from accepted `if_instr` to `ex_valid` and fields.
- Throughput: 1 instruction/cycle when `ex_ready`=1 and there is no hazard.
- Reset (`rst_n`=0 at edge): every output register is 0, including `ex_valid`, `ex_pc`, `ex_imm`, all controls and `ex_illegal`. `id_ready` is combinational and follows its equation.
- Reset mid-stall: reset wins and the held instruction is lost.
- Load-use costs exactly 1 bubble cycle. On the next cycle the LOAD has advanced, so `load_use` is 0 and the dependent instruction is accepted.
- `flush` coinciding with `load_use` or `ex_ready`=0 still kills the register in that cycle.
- Handshake: fetch holds `if_instr`/`if_pc` stable while `if_valid`=1 and `id_ready`=0.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles → all outputs 0. Release with `if_valid`=0 → `ex_valid` stays 0.
- **ALU stream:** `if_instr`=00400093, then 40110233, with `ex_ready`=1.
  - 00400093 → next cycle `ex_rd`=1, `ex_rs1`=0, `ex_imm`=4, `ex_aluOP`=000000, `ex_operandB`=1, `ex_regWrite`=1.
  - 40110233 → `ex_rd`=4, `ex_rs1`=2, `ex_rs2`=1, `ex_aluOP`=100000, `ex_operandB`=0.
- **Load-use:** 0000A283 (lw x5,0(x1)), then 00128333 (add x6,x5,x1).
  - LOAD registered with `ex_memToReg`=1.
  - Next cycle `id_ready`=0 and `ex_valid`→0 (bubble).
  - Following cycle: add accepted with `ex_rs1`=5.
  - With HAZARD_EN=0: no bubble.
- **Backpressure:** hold `ex_ready`=0 for 3 cycles with `ex_valid`=1 → fields unchanged and `id_ready`=0. Release → next instruction loads.
- **Flush:** `flush`=1 with `ex_valid`=1 and `ex_ready`=0 → next cycle `ex_valid`=0 and `id_ready`=1 in the flush cycle.
- **Illegal/masking:**
  - `if_instr`=0000007F → `ex_illegal`=1, `ex_regWrite`=0, `ex_memWrite`=0.
  - STORE 0010A023 → `ex_rd`=0, `ex_memWrite`=1.
